noc_inject_arbiter: RTL and testbench

//  Shares one ring-router local input port among NUM_REQ flit-level requesters (e.g. several

---
 rtl/noc_inject_arbiter.sv | 170 +++++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
// Shares one ring-router local input port among NUM_REQ flit-level requesters.
// A requester is granted round-robin and keeps the port until its tail flit is
// sent. The block owns the credit counter for the router input buffer and
// presents each accepted flit to the router one cycle after it is accepted.
module noc_inject_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*DEST_WIDTH-1:0] req_dest,
    input  logic [NUM_REQ-1:0]            req_is_tail,
    output logic                          out_send,
    output logic [FLIT_WIDTH-1:0]         out_data,
    output logic [DEST_WIDTH-1:0]         out_dest,
    output logic                          out_is_tail,
    input  logic                          credit_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          locked,
    output logic                          credit_err
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                state_r;
    logic [OW-1:0]         owner_r;
    logic [OW-1:0]         rr_ptr_r;
    logic                  locked_r;
    logic [CW-1:0]         credit_r;
    logic                  credit_err_r;
    logic                  out_send_r;
    logic [FLIT_WIDTH-1:0] out_data_r;
    logic [DEST_WIDTH-1:0] out_dest_r;
    logic                  out_is_tail_r;

    logic [NUM_REQ-1:0]    ready_s;
    logic                  xfer_s;
    logic                  has_credit_s;
    logic                  any_valid_s;
    logic [OW-1:0]         pick_s;
    logic [OW-1:0]         owner_next_s;

    // First valid requester at or after ptr, wrapping to the lowest valid one.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [OW-1:0]      ptr);
        logic [OW-1:0] hi_pick;
        logic [OW-1:0] lo_pick;
        logic          hi_found;
        hi_pick  = {OW{1'b0}};
        lo_pick  = {OW{1'b0}};
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                lo_pick = OW'(i);
                if (i >= int'(ptr)) begin
                    hi_pick  = OW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi_pick : lo_pick;
    endfunction

    assign has_credit_s = (credit_r != {CW{1'b0}});
    assign any_valid_s  = |req_valid;
    assign pick_s       = rr_pick(req_valid, rr_ptr_r);
    assign owner_next_s = (owner_r == OW'(NUM_REQ - 1)) ? {OW{1'b0}} : owner_r + OW'(1'b1);
    assign xfer_s       = |ready_s;

    // Only the locked owner may transfer, and only while the router has a free slot.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        if ((state_r == ST_LOCK) && has_credit_s) begin
            ready_s[owner_r] = req_valid[owner_r];
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Credit counter: consumed at the transfer so the next cycle already sees it gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r     <= CREDIT_MAX;
            credit_err_r <= 1'b0;
        end else begin
            case ({xfer_s, credit_in})
                2'b10: credit_r <= credit_r - CW'(1'b1);
                2'b01: begin
                    if (credit_r == CREDIT_MAX) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credit_r <= credit_r + CW'(1'b1);
                    end
                end
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Grant FSM: pick round-robin in IDLE, hold the lock until the tail transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            owner_r  <= {OW{1'b0}};
            locked_r <= 1'b0;
            rr_ptr_r <= {OW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        owner_r  <= pick_s;
                        locked_r <= 1'b1;
                        state_r  <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (xfer_s && req_is_tail[owner_r]) begin
                        locked_r <= 1'b0;
                        rr_ptr_r <= owner_next_s;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    locked_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Flit output register: send pulses one cycle after a transfer, payload holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_send_r    <= 1'b0;
            out_data_r    <= {FLIT_WIDTH{1'b0}};
            out_dest_r    <= {DEST_WIDTH{1'b0}};
            out_is_tail_r <= 1'b0;
        end else begin
            out_send_r <= xfer_s;
            if (xfer_s) begin
                out_data_r    <= req_data[owner_r*FLIT_WIDTH +: FLIT_WIDTH];
                out_dest_r    <= req_dest[owner_r*DEST_WIDTH +: DEST_WIDTH];
                out_is_tail_r <= req_is_tail[owner_r];
            end
        end
    end

    assign req_ready   = ready_s;
    assign out_send    = out_send_r;
    assign out_data    = out_data_r;
    assign out_dest    = out_dest_r;
    assign out_is_tail = out_is_tail_r;
    assign owner       = owner_r;
    assign locked      = locked_r;
    assign credit_err  = credit_err_r;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: directed scenarios plus a
// randomized multi-requester run checked against a packet-level reference.
`timescale 1ns/1ps
module tb_noc_inject_arbiter;

    localparam int NR    = 4;
    localparam int FW    = 128;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int OW    = 2;

    typedef struct {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
        int            src;
    } flit_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*FW-1:0] req_data;
    logic [NR*DW-1:0] req_dest;
    logic [NR-1:0]    req_is_tail;
    logic             out_send;
    logic [FW-1:0]    out_data;
    logic [DW-1:0]    out_dest;
    logic             out_is_tail;
    logic             credit_in;
    logic [OW-1:0]    owner;
    logic             locked;
    logic             credit_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    noc_inject_arbiter #(
        .NUM_REQ(NR), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_dest(req_dest), .req_is_tail(req_is_tail),
        .out_send(out_send), .out_data(out_data), .out_dest(out_dest),
        .out_is_tail(out_is_tail), .credit_in(credit_in),
        .owner(owner), .locked(locked), .credit_err(credit_err)
    );

    function automatic logic [FW-1:0] rand_flit();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_flit(input int r, input logic [FW-1:0] d, input logic [DW-1:0] ds,
                            input logic tl, input logic v);
        req_data[r*FW +: FW] = d;
        req_dest[r*DW +: DW] = ds;
        req_is_tail[r]       = tl;
        req_valid[r]         = v;
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        req_data    = '0;
        req_dest    = '0;
        req_is_tail = '0;
        credit_in   = 1'b0;
    endtask

    // One clock: acceptance sampled mid-cycle, returns 1ns after the rising edge.
    task automatic step(output logic [NR-1:0] acc);
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        tests_run++;
        if ({req_ready, out_send, out_is_tail, owner, locked, credit_err} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 0", {req_ready, out_send, out_is_tail, owner, locked, credit_err});
        end
        tests_run++;
        if ({out_data, out_dest} !== {(FW+DW){1'b0}}) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h required 0", out_data, out_dest);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_packet();
        logic [FW-1:0] d [3];
        logic [NR-1:0] acc;
        logic [2:0]    pipe;
        int            idx;
        int            nsent;
        int            send_cyc[$];
        do_reset();
        for (int i = 0; i < 3; i++) d[i] = rand_flit();
        idx   = 0;
        nsent = 0;
        pipe  = 3'b000;
        set_flit(0, d[0], 6'h15, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 16; cyc++) begin
            step(acc);
            if (acc[0]) idx++;
            if (idx < 3) set_flit(0, d[idx], 6'h15, idx == 2, 1'b1);
            else req_valid[0] = 1'b0;
            credit_in = pipe[1];
            pipe      = {pipe[1:0], out_send};
            if (out_send) begin
                tests_run++;
                if (nsent >= 3) begin
                    tests_failed++;
                    $display("FAIL single_extra_send: got send %0d required 3 sends only", nsent + 1);
                end else if (out_data !== d[nsent] || out_dest !== 6'h15 || out_is_tail !== (nsent == 2) ||
                             owner !== 2'd0 || locked !== (nsent != 2)) begin
                    tests_failed++;
                    $display("FAIL single_flit%0d: got %h/%h tail=%b own=%0d lk=%b required %h/15 tail=%b own=0 lk=%b",
                             nsent, out_data, out_dest, out_is_tail, owner, locked, d[nsent], nsent == 2, nsent != 2);
                end
                send_cyc.push_back(cyc);
                nsent++;
            end
        end
        tests_run++;
        if (!(send_cyc.size() == 3 && (send_cyc[2] - send_cyc[0]) == 2)) begin
            tests_failed++;
            $display("FAIL single_consecutive: got %0d sends required 3 on consecutive cycles", send_cyc.size());
        end
        tests_run++;
        if ({locked, credit_err, req_ready} !== 6'd0) begin
            tests_failed++;
            $display("FAIL single_end: got lk=%b err=%b rdy=%b required 0", locked, credit_err, req_ready);
        end
    endtask

    task automatic test_credit_exhaust();
        logic [NR-1:0] acc;
        int            sends;
        do_reset();
        sends = 0;
        set_flit(0, rand_flit(), 6'h2A, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 12; cyc++) begin
            step(acc);
            if (out_send) sends++;
            set_flit(0, rand_flit(), 6'h2A, 1'b0, 1'b1);
        end
        tests_run++;
        if (sends != DEPTH || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL exhaust_stall: got %0d sends rdy=%b required %0d sends rdy=0000", sends, req_ready, DEPTH);
        end
        sends     = 0;
        credit_in = 1'b1;
        step(acc);
        credit_in = 1'b0;
        if (out_send) sends++;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step(acc);
            if (out_send) sends++;
        end
        tests_run++;
        if (sends != 1 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL exhaust_one_credit: got %0d sends rdy=%b required 1 send rdy=0000", sends, req_ready);
        end
    endtask

    task automatic test_credit_same_cycle();
        logic [NR-1:0] acc;
        int            acc_cnt;
        do_reset();
        acc_cnt = 0;
        set_flit(0, rand_flit(), 6'h07, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (acc_cnt >= 2) break;
            step(acc);
            if (acc[0]) acc_cnt++;
            set_flit(0, rand_flit(), 6'h07, 1'b0, acc_cnt < 2);
        end
        tests_run++;
        if (acc_cnt != 2) begin
            tests_failed++;
            $display("FAIL same_cycle_setup: got %0d accepts required 2", acc_cnt);
        end
        set_flit(0, rand_flit(), 6'h07, 1'b0, 1'b1);
        credit_in = 1'b1;
        step(acc);
        credit_in = 1'b0;
        tests_run++;
        if (acc[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_cycle_xfer: got accept=%b required 1", acc[0]);
        end
        acc_cnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            set_flit(0, rand_flit(), 6'h07, 1'b0, 1'b1);
            step(acc);
            if (acc[0]) acc_cnt++;
        end
        tests_run++;
        if (acc_cnt != 2 || credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_count: got %0d further accepts err=%b required 2 err=0", acc_cnt, credit_err);
        end
    endtask

    task automatic test_credit_overflow();
        logic [NR-1:0] acc;
        int            sends;
        do_reset();
        credit_in = 1'b1;
        step(acc);
        credit_in = 1'b0;
        tests_run++;
        if (credit_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_flag: got %b required 1", credit_err);
        end
        sends = 0;
        set_flit(0, rand_flit(), 6'h3C, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 12; cyc++) begin
            step(acc);
            if (out_send) sends++;
            set_flit(0, rand_flit(), 6'h3C, 1'b0, 1'b1);
        end
        tests_run++;
        if (sends != DEPTH || credit_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_saturate: got %0d sends err=%b required %0d sends err=1", sends, credit_err, DEPTH);
        end
    endtask

    task automatic test_mid_packet_reset();
        logic [NR-1:0] acc;
        logic [FW-1:0] h0;
        logic [FW-1:0] h2;
        int            acc_cnt;
        bit            seen;
        do_reset();
        set_flit(1, rand_flit(), 6'h11, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 6; cyc++) begin
            step(acc);
            if (acc[1]) req_valid[1] = 1'b0;
        end
        acc_cnt = 0;
        set_flit(2, rand_flit(), 6'h22, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (acc_cnt >= 2) break;
            step(acc);
            if (acc[2]) acc_cnt++;
            set_flit(2, rand_flit(), 6'h22, 1'b0, 1'b1);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, out_send, out_is_tail, owner, locked, credit_err} !== 9'd0 ||
            {out_data, out_dest} !== {(FW+DW){1'b0}}) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got ctl=%b data=%h dest=%h required all 0",
                     {req_ready, out_send, out_is_tail, owner, locked, credit_err}, out_data, out_dest);
        end
        @(posedge clk);
        #1;
        h0 = rand_flit();
        h2 = rand_flit();
        set_flit(0, h0, 6'h01, 1'b1, 1'b1);
        set_flit(2, h2, 6'h02, 1'b1, 1'b1);
        credit_in = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step(acc);
            if (acc[0]) req_valid[0] = 1'b0;
            if (acc[2]) req_valid[2] = 1'b0;
            if (out_send && !seen) begin
                seen = 1'b1;
                tests_run++;
                if (out_data !== h0 || owner !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL midreset_first_grant: got %h own=%0d required %h own=0", out_data, owner, h0);
                end
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL midreset_timeout: got no send required a send within 10 cycles");
        end
    endtask

    task automatic test_random_rr();
        localparam int NPKT = 5;
        localparam int MAXF = 24;
        logic [FW-1:0] f_data [NR][MAXF];
        logic [DW-1:0] f_dest [NR][MAXF];
        logic          f_tail [NR][MAXF];
        logic          f_head [NR][MAXF];
        int            nfl [NR];
        int            ptr [NR];
        flit_t         exp_q[$];
        flit_t         e;
        int            due_q[$];
        logic [NR-1:0] acc;
        int            len;
        int            due;
        int            sent;
        int            returned;
        int            cyc;
        int            stray;
        for (int r = 0; r < NR; r++) begin
            nfl[r] = 0;
            ptr[r] = 0;
        end
        for (int k = 0; k < NPKT; k++) begin
            for (int r = 0; r < NR; r++) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    e.data = rand_flit();
                    e.dest = DW'($urandom_range(0, 63));
                    e.tail = (j == len - 1);
                    e.src  = r;
                    f_data[r][nfl[r]] = e.data;
                    f_dest[r][nfl[r]] = e.dest;
                    f_tail[r][nfl[r]] = e.tail;
                    f_head[r][nfl[r]] = (j == 0);
                    nfl[r]++;
                    exp_q.push_back(e);
                end
            end
        end
        do_reset();
        sent = 0;
        returned = 0;
        cyc = 0;
        for (int r = 0; r < NR; r++) set_flit(r, f_data[r][0], f_dest[r][0], f_tail[r][0], 1'b1);
        while (exp_q.size() > 0 && cyc < 3000) begin
            step(acc);
            for (int r = 0; r < NR; r++) if (acc[r]) ptr[r]++;
            if (credit_in) returned++;
            credit_in = 1'b0;
            if (out_send) begin
                sent++;
                due = cyc + int'($urandom_range(1, 4));
                if (due_q.size() > 0 && due < due_q[$]) due = due_q[$];
                due_q.push_back(due);
                e = exp_q.pop_front();
                tests_run++;
                if (out_data !== e.data || out_dest !== e.dest || out_is_tail !== e.tail || owner !== OW'(e.src)) begin
                    tests_failed++;
                    $display("FAIL rr_flit: got %h/%h tail=%b own=%0d required %h/%h tail=%b own=%0d",
                             out_data, out_dest, out_is_tail, owner, e.data, e.dest, e.tail, e.src);
                end
                tests_run++;
                if (sent - returned > DEPTH) begin
                    tests_failed++;
                    $display("FAIL rr_credit_limit: got %0d outstanding required <= %0d", sent - returned, DEPTH);
                end
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                credit_in = 1'b1;
                void'(due_q.pop_front());
            end
            for (int r = 0; r < NR; r++) begin
                if (ptr[r] < nfl[r]) begin
                    set_flit(r, f_data[r][ptr[r]], f_dest[r][ptr[r]], f_tail[r][ptr[r]],
                             f_head[r][ptr[r]] ? 1'b1 : ($urandom_range(0, 3) != 0));
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            cyc++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rr_timeout: got %0d flits missing required 0", exp_q.size());
        end
        credit_in = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step(acc);
            if (out_send) stray++;
        end
        tests_run++;
        if (stray != 0 || locked !== 1'b0 || credit_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain: got %0d stray sends lk=%b err=%b required 0/0/0", stray, locked, credit_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_credit_exhaust();
        test_credit_same_cycle();
        test_credit_overflow();
        test_mid_packet_reset();
        test_random_rr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion required finish within 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
